regfile_valid: RTL
==================

Name: regfile_valid

Overview:
Per-architectural-register valid tracker that sits directly downstream of the rename source table (regfileSource) and consumes its rf_source/sr_source outputs.
- A register goes invalid when a queued instruction targets it.
- It goes valid again when the ROB entry recorded as its latest writer commits.
- On a branch miss it is restored from a pending-writer mask.
- Issue logic reads rf_v/sr_v to decide whether an operand comes from the register file or waits on a ROB tag.

Parameters:
AREGS, 32, number of architectural registers; register 0 is hardwired valid.
RW, 5, register index width, equal to $clog2(AREGS).
RIDW, 4, ROB id width; source tags are RIDW+1 bits, MSB set = "no pending writer".
QSLOTS, 3, queue slots per cycle; fixed at 3 by the slot decode.
CSLOTS, 2, commit ports per cycle.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
branchmiss  in  1  pipeline flush this cycle
miss_pend  in  AREGS  registers that still have a live pending writer after the flush
miss_sr_pend  in  1  status register still has a live pending writer after the flush
slotv  in  QSLOTS  slot holds a valid instruction
queuedOn  in  QSLOTS  slot was accepted into the queue this cycle
slot_rfw  in  QSLOTS  slot writes the register file
slot_srw  in  QSLOTS  slot writes the status register
Rd  in  QSLOTS x RW  destination register per slot
cmt_v  in  CSLOTS  commit port valid
cmt_rfw  in  CSLOTS  committing entry writes the register file
cmt_srw  in  CSLOTS  committing entry writes the status register
cmt_tgt  in  CSLOTS x RW  committing destination register
cmt_id  in  CSLOTS x RIDW  committing ROB id
rf_source  in  AREGS x (RIDW+1)  latest-writer tag per register, from regfileSource
sr_source  in  RIDW+1  latest-writer tag for the status register
rf_v  out  AREGS  register value is architecturally valid
sr_v  out  1  status register is valid
pend_cnt  out  RW+1  number of registers currently invalid

Behaviour:
- Reset: rf_v = all ones, sr_v = 1, pend_cnt = 0. Reset overrides every other input in that cycle.
- Slot k is taken when:
  - slotv[k] & queuedOn[k], and
  - every lower slot j with slotv[j] set also has queuedOn[j] set.
  - This is the same in-order chain regfileSource uses.
- Queue invalidate (only when branchmiss = 0): for each taken slot k:
  - slot_rfw[k] & Rd[k] != 0 clears rf_v[Rd[k]].
  - slot_srw[k] clears sr_v.
- Commit validate: for each port c with cmt_v[c] & cmt_rfw[c] & cmt_tgt[c] != 0:
  - Set rf_v[cmt_tgt[c]] only if rf_source[cmt_tgt[c]] == {1'b0, cmt_id[c]}.
  - If the tags do not match, a younger writer exists and rf_v stays 0.
  - sr_v is set the same way from cmt_srw[c] against sr_source.
- Priority inside a normal cycle:
  - A queue invalidate beats a commit validate on the same register.
  - rf_source sampled this cycle is the pre-update tag, so a commit matching the old tag must not set a register that is simultaneously re-targeted.
  - Two commit ports hitting the same register: either match sets it; the result is idempotent.
- Branch miss cycle:
  - rf_v <= ~miss_pend with bit 0 forced to 1; sr_v <= ~miss_sr_pend.
  - Queue slots are ignored.
  - Commits are then applied on top of the restored value, with the same tag-match rule against the rf_source input of that cycle.
- rf_v[0] is 1 at all times, including when Rd = 0 or cmt_tgt = 0.
- pend_cnt is registered and equals the popcount of ~rf_v over the state being written. It updates in the same edge as rf_v, has zero-cycle lag relative to rf_v, and ranges 0..AREGS-1.
- Latency: one clock from queue or commit to rf_v. There is no combinational path from inputs to outputs.
- Simulation check: $stop if any taken slot has Rd >= AREGS.
- A branchmiss asserted concurrently with rst has no effect.

Test Plan:
1. Reset, then idle 3 cycles -> rf_v = 32'hFFFF_FFFF, sr_v = 1, pend_cnt = 0.
2. slotv = 3'b111, queuedOn = 3'b011, slot_rfw = 3'b111, Rd = {7, 5, 3} -> rf_v[3] = rf_v[5] = 0, rf_v[7] stays 1, pend_cnt = 2.
3. From state 2, rf_source[5] = 5'h04:
   - cmt_v = 2'b01, tgt = 5, id = 4 -> rf_v[5] = 1.
   - Repeat the test with rf_source[5] = 5'h06 -> rf_v[5] stays 0.
4. Same cycle: slot0 queues Rd = 9 while commit port 1 commits tgt 9, id matching the current rf_source[9] -> rf_v[9] = 0.
5. branchmiss = 1, miss_pend = 32'h0000_0104, slot0 queued with Rd = 12 -> rf_v = 32'hFFFF_FEFB (bits 2 and 8 clear, 12 set), pend_cnt = 2.
6. Queue Rd = 0 and commit tgt = 0 -> rf_v[0] = 1 and pend_cnt unchanged. Then assert rst with branchmiss = 1 and miss_pend = 32'hFFFF_FFFF -> all valid, pend_cnt = 0.

Source files
------------

// File: rtl/regfile_valid.sv
// Architectural register valid tracker.
// Registers are invalidated when a queued instruction targets them, and
// re-validated when their latest recorded writer commits. On a branch miss
// the state is rebuilt from the surviving pending-writer mask.

// Per-register cell: decides whether this register is re-targeted by a
// queued slot and whether a commit port matches its latest-writer tag.
module regfile_valid_cell #(
  parameter int RW     = 5,
  parameter int RIDW   = 4,
  parameter int QSLOTS = 3,
  parameter int CSLOTS = 2,
  parameter int IDX    = 0
) (
  input  logic [QSLOTS-1:0]           q_wr,
  input  logic [QSLOTS-1:0][RW-1:0]   rd,
  input  logic [CSLOTS-1:0]           c_wr,
  input  logic [CSLOTS-1:0][RW-1:0]   c_tgt,
  input  logic [CSLOTS-1:0][RIDW-1:0] c_id,
  input  logic [RIDW:0]               src,
  output logic                        inv,
  output logic                        set
);
  // Match queue destinations and tag-checked commits against this index.
  always_comb begin
    inv = 1'b0;
    set = 1'b0;
    for (int k = 0; k < QSLOTS; k++)
      if (q_wr[k] && rd[k] == RW'(IDX)) inv = 1'b1;
    for (int c = 0; c < CSLOTS; c++)
      if (c_wr[c] && c_tgt[c] == RW'(IDX) && src == {1'b0, c_id[c]}) set = 1'b1;
  end
endmodule

module regfile_valid #(
  parameter int AREGS  = 32,
  parameter int RW     = 5,
  parameter int RIDW   = 4,
  parameter int QSLOTS = 3,
  parameter int CSLOTS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           branchmiss,
  input  logic [AREGS-1:0]               miss_pend,
  input  logic                           miss_sr_pend,
  input  logic [QSLOTS-1:0]              slotv,
  input  logic [QSLOTS-1:0]              queuedOn,
  input  logic [QSLOTS-1:0]              slot_rfw,
  input  logic [QSLOTS-1:0]              slot_srw,
  input  logic [QSLOTS-1:0][RW-1:0]      Rd,
  input  logic [CSLOTS-1:0]              cmt_v,
  input  logic [CSLOTS-1:0]              cmt_rfw,
  input  logic [CSLOTS-1:0]              cmt_srw,
  input  logic [CSLOTS-1:0][RW-1:0]      cmt_tgt,
  input  logic [CSLOTS-1:0][RIDW-1:0]    cmt_id,
  input  logic [AREGS-1:0][RIDW:0]       rf_source,
  input  logic [RIDW:0]                  sr_source,
  output logic [AREGS-1:0]               rf_v,
  output logic                           sr_v,
  output logic [RW:0]                    pend_cnt
);
  logic [QSLOTS-1:0] taken;
  logic [QSLOTS-1:0] q_wr;
  logic [CSLOTS-1:0] c_wr;
  logic [AREGS-1:0]  inv_mask, set_mask, rf_nxt;
  logic              sr_inv, sr_set, sr_nxt;
  logic [RW:0]       cnt_nxt;

  // In-order take chain: a slot is taken only if no lower valid slot stalled.
  always_comb begin
    logic ok;
    ok    = 1'b1;
    taken = '0;
    for (int k = 0; k < QSLOTS; k++) begin
      taken[k] = slotv[k] & queuedOn[k] & ok;
      ok       = ok & (~slotv[k] | queuedOn[k]);
    end
  end

  // Queue slots are ignored entirely during a flush.
  assign q_wr = taken & slot_rfw & {QSLOTS{~branchmiss}};
  assign c_wr = cmt_v & cmt_rfw;

  for (genvar i = 0; i < AREGS; i++) begin : g_cell
    regfile_valid_cell #(
      .RW(RW), .RIDW(RIDW), .QSLOTS(QSLOTS), .CSLOTS(CSLOTS), .IDX(i)
    ) u_cell (
      .q_wr(q_wr), .rd(Rd), .c_wr(c_wr), .c_tgt(cmt_tgt), .c_id(cmt_id),
      .src(rf_source[i]), .inv(inv_mask[i]), .set(set_mask[i])
    );
  end

  // Status register: same invalidate/validate rules against sr_source.
  always_comb begin
    sr_inv = ~branchmiss & |(taken & slot_srw);
    sr_set = 1'b0;
    for (int c = 0; c < CSLOTS; c++)
      if (cmt_v[c] && cmt_srw[c] && sr_source == {1'b0, cmt_id[c]}) sr_set = 1'b1;
  end

  // Next state: base (held or restored), commits on top, invalidates win.
  always_comb begin
    logic [AREGS-1:0] base;
    base      = branchmiss ? ~miss_pend : rf_v;
    rf_nxt    = (base | set_mask) & ~inv_mask;
    rf_nxt[0] = 1'b1;
    sr_nxt    = ((branchmiss ? ~miss_sr_pend : sr_v) | sr_set) & ~sr_inv;
    cnt_nxt   = '0;
    for (int i = 0; i < AREGS; i++)
      cnt_nxt = cnt_nxt + {{RW{1'b0}}, ~rf_nxt[i]};
  end

  // State register; pend_cnt tracks the same written value with no lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_v     <= '1;
      sr_v     <= 1'b1;
      pend_cnt <= '0;
    end else begin
      rf_v     <= rf_nxt;
      sr_v     <= sr_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

`ifndef SYNTHESIS
  // Halt simulation on an out-of-range destination from a taken slot.
  always_ff @(posedge clk) begin
    if (!rst)
      for (int k = 0; k < QSLOTS; k++)
        if (taken[k]) assert (32'(Rd[k]) < AREGS) else $stop;
  end
`endif
endmodule
